// File: rtl/lock_pkg.sv
// Shared types and sizing for the combination-lock keypad front end.
package lock_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam int unsigned NDIG    = 4;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned CODE_W  = NDIG * DIGIT_W;
  localparam int unsigned NDIG_W  = 3;

endpackage

// File: rtl/entry_timer.sv
// Inactivity counter: runs while enabled, restarts on reload, flags the last idle cycle.
module entry_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TW             = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic reload_i,
  output logic expired_c
);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  // Expiry is seen in the cycle the count sits at its final value.
  always_comb begin
    expired_c = en_i && (count_q == TW'(TIMEOUT_CYCLES - 1));
    count_d   = count_q + TW'(1);
    if (reload_i || !en_i || expired_c) begin
      count_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry: gathers four hex digits, presents a held code plus submit/error/timeout pulses.
module keypad_entry
  import lock_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TW             = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DIGIT_W-1:0] key_code,
  input  logic               key_valid,
  input  logic               key_back,
  input  logic               key_clear,
  input  logic               key_enter,
  input  logic               lockout,
  output logic [DIGIT_W-1:0] digit_1,
  output logic [DIGIT_W-1:0] digit_2,
  output logic [DIGIT_W-1:0] digit_3,
  output logic [DIGIT_W-1:0] digit_4,
  output logic               entry_valid,
  output logic               entry_err,
  output logic               timeout,
  output logic [NDIG_W-1:0]  ndig
);

  state_e              state_q;
  logic [CODE_W-1:0]   buf_q;
  logic [NDIG_W-1:0]   ndig_q;
  logic [CODE_W-1:0]   code_q;
  logic                entry_valid_q;
  logic                entry_err_q;
  logic                timeout_q;

  logic do_clear_c;
  logic do_enter_c;
  logic do_back_c;
  logic do_digit_c;
  logic empty_c;
  logic full_c;
  logic reload_c;
  logic expired_c;

  // Single-winner event decode; lockout masks every strobe.
  always_comb begin
    do_clear_c = !lockout && key_clear;
    do_enter_c = !lockout && !key_clear && key_enter;
    do_back_c  = !lockout && !key_clear && !key_enter && key_back;
    do_digit_c = !lockout && !key_clear && !key_enter && !key_back && key_valid;
    empty_c    = (ndig_q == '0);
    full_c     = (ndig_q == NDIG_W'(NDIG));
    reload_c   = do_clear_c || do_enter_c || (do_back_c && !empty_c) ||
                 (do_digit_c && !full_c);
  end

  entry_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TW            (TW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .en_i     (state_q != IDLE),
    .reload_i (reload_c),
    .expired_c(expired_c)
  );

  // Entry FSM with shift buffer, submitted code and one-cycle status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      buf_q         <= '0;
      ndig_q        <= '0;
      code_q        <= '0;
      entry_valid_q <= 1'b0;
      entry_err_q   <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      entry_valid_q <= 1'b0;
      entry_err_q   <= 1'b0;
      timeout_q     <= 1'b0;
      if (do_clear_c) begin
        buf_q   <= '0;
        ndig_q  <= '0;
        state_q <= IDLE;
      end else if (do_enter_c) begin
        if (full_c) begin
          code_q        <= buf_q;
          entry_valid_q <= 1'b1;
        end else begin
          entry_err_q   <= 1'b1;
        end
        buf_q   <= '0;
        ndig_q  <= '0;
        state_q <= IDLE;
      end else if (do_back_c) begin
        if (empty_c) begin
          entry_err_q <= 1'b1;
        end else begin
          buf_q   <= {DIGIT_W'(0), buf_q[CODE_W-1:DIGIT_W]};
          ndig_q  <= ndig_q - NDIG_W'(1);
          state_q <= (ndig_q == NDIG_W'(1)) ? IDLE : ENTRY;
        end
      end else if (do_digit_c && !full_c) begin
        buf_q   <= {buf_q[CODE_W-DIGIT_W-1:0], key_code};
        ndig_q  <= ndig_q + NDIG_W'(1);
        state_q <= (ndig_q == NDIG_W'(NDIG - 1)) ? FULL : ENTRY;
      end else if (expired_c) begin
        // A rejected digit in the expiry cycle does not rescue the entry.
        buf_q     <= '0;
        ndig_q    <= '0;
        state_q   <= IDLE;
        timeout_q <= 1'b1;
      end else if (do_digit_c) begin
        entry_err_q <= 1'b1;
      end
    end
  end

  assign digit_1     = code_q[15:12];
  assign digit_2     = code_q[11:8];
  assign digit_3     = code_q[7:4];
  assign digit_4     = code_q[3:0];
  assign entry_valid = entry_valid_q;
  assign entry_err   = entry_err_q;
  assign timeout     = timeout_q;
  assign ndig        = ndig_q;

endmodule
